// File: rtl/uart_load_ctrl.sv
// rtl/uart_load_ctrl.sv - UART program loader sharing the memory port with a CPU
// UART words take the memory port over the CPU. A finished or timed-out load restarts the CPU.
module uart_load_ctrl #(
   parameter int MEM_WORDS  = 16384,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_wvalid,
   input  logic [31:0] uart_addr,
   input  logic [31:0] uart_data,
   input  logic        uart_done,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_stall,
   output logic        cpu_rst,
   output logic        loading,
   output logic [15:0] word_cnt,
   output logic        err
);

   typedef enum logic [1:0] {RUN, LOAD, RESTART} state_t;

   localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);
   localparam logic [31:0] IDLE_LAST  = 32'(TIMEOUT - 2);
   localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);

   state_t      state;
   logic [31:0] idle_cnt;
   logic [31:0] rst_cnt;
   logic        accept;
   logic [15:0] cnt_next;

   assign accept   = (uart_addr[1:0] == 2'b00) && ({1'b0, uart_addr} < ADDR_LIMIT);
   assign cnt_next = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (uart_wvalid) begin
         mem_we    = accept;
         mem_addr  = uart_addr;
         mem_wdata = uart_data;
      end else if (state == RUN) begin
         mem_we    = cpu_req & cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_stall = (state != RUN) | uart_wvalid;
   assign loading   = (state != RUN);
   assign cpu_rst   = (state == RESTART);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         idle_cnt <= 32'd0;
         rst_cnt  <= 32'd0;
         word_cnt <= 16'd0;
         err      <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               rst_cnt <= 32'd0;
               if (uart_wvalid) begin
                  // A new load starts from a clean count and error flag.
                  state    <= LOAD;
                  idle_cnt <= 32'd0;
                  word_cnt <= accept ? 16'd1 : 16'd0;
                  err      <= ~accept;
               end
            end
            LOAD: begin
               rst_cnt <= 32'd0;
               if (uart_wvalid) begin
                  idle_cnt <= 32'd0;
                  if (accept) word_cnt <= cnt_next;
                  else        err      <= 1'b1;
                  if (uart_done) state <= RESTART;
               end else if (uart_done) begin
                  state <= RESTART;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
                  if (idle_cnt == IDLE_LAST) begin
                     err   <= 1'b1;
                     state <= RESTART;
                  end
               end
            end
            RESTART: begin
               if (uart_wvalid) begin
                  // Late word: resume loading, keep the running count and error.
                  state    <= LOAD;
                  rst_cnt  <= 32'd0;
                  idle_cnt <= 32'd0;
                  if (accept) word_cnt <= cnt_next;
                  else        err      <= 1'b1;
               end else if (rst_cnt == RST_LAST) begin
                  state   <= RUN;
                  rst_cnt <= 32'd0;
               end else begin
                  rst_cnt <= rst_cnt + 32'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// tb/tb_uart_load_ctrl.sv - scoreboard bench for uart_load_ctrl
module tb_uart_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_wvalid;
   logic [31:0] uart_addr;
   logic [31:0] uart_data;
   logic        uart_done;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_stall;
   logic        cpu_rst;
   logic        loading;
   logic [15:0] word_cnt;
   logic        err;

   int n_vec  = 0;
   int n_miss = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   uart_load_ctrl #(.MEM_WORDS(16), .RST_CYCLES(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .uart_wvalid(uart_wvalid), .uart_addr(uart_addr), .uart_data(uart_data), .uart_done(uart_done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_stall(cpu_stall), .cpu_rst(cpu_rst), .loading(loading),
      .word_cnt(word_cnt), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every memory write must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_miss++;
               $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                        mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      uart_wvalid = 0; uart_addr = 0; uart_data = 0; uart_done = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
   endtask

   // Present a UART word for one cycle; good=1 means a write is expected.
   task automatic uart_word(input logic [31:0] a, input logic [31:0] d, input bit good, input bit done);
      uart_wvalid = 1; uart_addr = a; uart_data = d; uart_done = done;
      if (good) exp_q.push_back({a, d});
      @(negedge clk);
      chk("stall_on_uart", 32'(cpu_stall), 32'd1);
      tick();
      clear_in();
   endtask

   task automatic done_pulse();
      uart_done = 1;
      tick();
      uart_done = 0;
   endtask

   task automatic expect_restart_pulse(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_cpu_rst_high"}, 32'(cpu_rst), 32'd1);
         tick();
      end
      chk({tag, "_cpu_rst_low"}, 32'(cpu_rst), 32'd0);
      chk({tag, "_back_to_run"}, 32'(loading), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in();
      rst = 1;
      tick();
      // Reset with a UART strobe: port follows UART, stall follows strobe, no state change.
      uart_wvalid = 1; uart_addr = 32'h30; uart_data = 32'hDEAD0001;
      exp_q.push_back({32'h30, 32'hDEAD0001});
      @(negedge clk);
      chk("rst_stall", 32'(cpu_stall), 32'd1);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
      tick();
      clear_in();
      chk("rst_loading", 32'(loading), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 0;
      tick();
      chk("run_stall", 32'(cpu_stall), 32'd0);

      // CPU pass-through, then a CPU read (no write), then uart_done ignored in RUN.
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAB;
      exp_q.push_back({32'h10, 32'hAB});
      @(negedge clk);
      chk("cpu_pass_stall", 32'(cpu_stall), 32'd0);
      tick();
      cpu_we = 0;
      tick();
      clear_in();
      done_pulse();
      chk("done_in_run_ignored", 32'(loading), 32'd0);

      // Collision plus normal load of three words.
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
      uart_word(32'h0, 32'h11111111, 1, 0);
      chk("collision_to_load", 32'(loading), 32'd1);
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h66;
      tick();
      clear_in();
      uart_word(32'h4, 32'h22222222, 1, 0);
      tick();
      uart_word(32'h8, 32'h33333333, 1, 0);
      done_pulse();
      chk("load_word_cnt", 32'(word_cnt), 32'd3);
      expect_restart_pulse("load");
      chk("load_err", 32'(err), 32'd0);

      // Bad addresses: misaligned then out of range.
      uart_word(32'h2, 32'h44444444, 0, 0);
      chk("bad_misaligned_cnt", 32'(word_cnt), 32'd0);
      chk("bad_misaligned_err", 32'(err), 32'd1);
      uart_word(32'd64, 32'h55555555, 0, 0);
      chk("bad_range_cnt", 32'(word_cnt), 32'd0);
      uart_word(32'h3C, 32'h66666666, 1, 1);
      chk("last_addr_cnt", 32'(word_cnt), 32'd1);
      chk("err_sticky", 32'(err), 32'd1);
      expect_restart_pulse("bad");
      chk("err_kept_in_run", 32'(err), 32'd1);

      // New load clears err; re-entry during second restart cycle.
      uart_word(32'h4, 32'h77777777, 1, 0);
      chk("new_load_err_clr", 32'(err), 32'd0);
      chk("new_load_cnt", 32'(word_cnt), 32'd1);
      done_pulse();
      chk("reentry_r1", 32'(cpu_rst), 32'd1);
      tick();
      uart_wvalid = 1; uart_addr = 32'h8; uart_data = 32'h88888888;
      exp_q.push_back({32'h8, 32'h88888888});
      @(negedge clk);
      chk("reentry_r2_rst", 32'(cpu_rst), 32'd1);
      tick();
      clear_in();
      chk("reentry_rst_drop", 32'(cpu_rst), 32'd0);
      chk("reentry_loading", 32'(loading), 32'd1);
      chk("reentry_cnt", 32'(word_cnt), 32'd2);
      done_pulse();
      expect_restart_pulse("reentry");

      // Timeout: one word, then idle until RESTART 16 cycles after the word.
      uart_word(32'hC, 32'h99999999, 1, 0);
      for (int k = 1; k < 16; k++) begin
         if (cpu_rst !== 1'b0 || loading !== 1'b1) begin
            n_miss++;
            $display("FAIL timeout_early: cycle %0d cpu_rst=%0b loading=%0b", k, cpu_rst, loading);
         end
         tick();
      end
      chk("timeout_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("timeout_err", 32'(err), 32'd1);
      expect_restart_pulse("timeout");
      chk("timeout_cnt", 32'(word_cnt), 32'd1);

      // Reset during a load aborts with no restart pulse.
      uart_word(32'h0, 32'hAAAAAAAA, 1, 0);
      rst = 1;
      tick();
      rst = 0;
      chk("abort_loading", 32'(loading), 32'd0);
      chk("abort_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("abort_cnt", 32'(word_cnt), 32'd0);
      tick();
      chk("abort_no_pulse", 32'(cpu_rst), 32'd0);

      tick();
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_load_ctrl.md
UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- MEM_WORDS, 16384, memory depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-4.
- RST_CYCLES, 4, length in cycles of the CPU restart pulse after a load.
- TIMEOUT, 1000000, number of idle LOAD cycles that aborts a load.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports, one per line: name, direction, width, meaning.
- clk in 1: system clock.
- rst in 1: synchronous active-high reset.
- uart_wvalid in 1: one-cycle strobe, an assembled UART word is present.
- uart_addr in 32: byte address of the UART word.
- uart_data in 32: UART word data.
- uart_done in 1: one-cycle strobe, end of transfer.
- cpu_req in 1: CPU memory access request.
- cpu_we in 1: CPU write enable.
- cpu_addr in 32: CPU byte address.
- cpu_wdata in 32: CPU write data.
- mem_we out 1: memory write enable.
- mem_addr out 32: memory byte address.
- mem_wdata out 32: memory write data.
- cpu_stall out 1: CPU must hold its state.
- cpu_rst out 1: CPU restart request.
- loading out 1: a load is in progress.
- word_cnt out 16: number of accepted UART words in the current or last load.
- err out 1: sticky load error.

Function
REQ-003 The FSM SHALL have three states: RUN, LOAD and RESTART.
REQ-004 The memory port mux SHALL be combinational, with UART priority:
- if uart_wvalid=1: mem_addr=uart_addr, mem_wdata=uart_data, mem_we=accept.
- else if state=RUN: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we.
- else: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-005 accept SHALL equal uart_addr[1:0]==0 AND uart_addr < 4*MEM_WORDS.
REQ-006 cpu_stall SHALL equal (state!=RUN) OR uart_wvalid.
REQ-007 loading SHALL equal (state!=RUN).
REQ-008 In RUN, uart_wvalid SHALL cause a move to LOAD next cycle; in that same cycle word_cnt is cleared, err is cleared and the word is written per REQ-004. The cleared word_cnt and err values are then updated by this word per REQ-009 and REQ-010.
REQ-009 On uart_wvalid with accept=1 in any state, word_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-010 On uart_wvalid with accept=0, the write SHALL be suppressed, word_cnt SHALL not change, and err SHALL be set to 1.
REQ-011 In LOAD, a 32-bit idle counter SHALL:
- clear on every uart_wvalid;
- otherwise increment;
- on reaching TIMEOUT-1 without uart_wvalid, set err=1 and move to RESTART.
REQ-012 In LOAD, uart_done SHALL cause a move to RESTART next cycle. If uart_wvalid arrives in the same cycle, that word is written first.
REQ-013 In RESTART, cpu_rst SHALL be 1 for exactly RST_CYCLES consecutive cycles, then the FSM moves to RUN. cpu_rst SHALL be 0 in every other state.
REQ-014 In RESTART, uart_wvalid SHALL:
- write the word per REQ-004;
- return the FSM to LOAD;
- clear the restart counter;
- keep word_cnt and err (no clear).
REQ-015 uart_done in RUN or RESTART SHALL be ignored.
REQ-016 All CPU requests in LOAD and RESTART SHALL be dropped, not queued. The CPU holds them via cpu_stall.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL set:
- state=RUN;
- idle and restart counters to 0;
- word_cnt=0, err=0.
rst SHALL override all other inputs in that cycle.
REQ-018 During and after reset, outputs SHALL be cpu_rst=0, loading=0 and cpu_stall=uart_wvalid. A reset in LOAD or RESTART SHALL abort the load with no restart pulse.

Verification
REQ-019 CPU pass-through in RUN: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xAB -> mem_we=1, mem_addr=0x10, mem_wdata=0xAB, cpu_stall=0.
REQ-020 Normal load: words to 0x0, 0x4, 0x8, then uart_done -> three writes, word_cnt=3, cpu_rst high 4 cycles, then RUN with err=0.
REQ-021 Collision: in RUN, uart_wvalid (addr 0x0) and a CPU write to 0x20 in the same cycle -> only the UART write occurs, cpu_stall=1, next state LOAD.
REQ-022 Bad addresses: uart_addr=0x2 and then uart_addr=4*MEM_WORDS -> no writes, word_cnt unchanged, err=1 until the next load starts.
REQ-023 Timeout with TIMEOUT=16: one word, then idle -> RESTART entered 16 cycles after the word, err=1.
REQ-024 Re-entry: uart_wvalid during cycle 2 of RESTART -> word written, state LOAD, cpu_rst drops; a later uart_done gives a full 4-cycle cpu_rst pulse.
